ll_fifo_arbiter: RTL and testbench
==================================

Name: ll_fifo_arbiter

Overview:
- Front-end scheduler for the shared linked-list multi-queue FIFO (NUM_FIFOS logical queues sharing DEPTH entries).
- Arbitrates independent per-queue push requesters and per-queue pop consumers with round-robin fairness.
- Tracks per-queue and total occupancy internally, so it never issues a push to a full structure or a pop to an empty queue.
- Drives the shared FIFO's push/pop/push_sel/pop_sel/data_in from registers.

Parameters:
WIDTH, 8, data word width
DEPTH, 4, total shared entries (power of two)
NUM_FIFOS, 2, number of logical queues (>=2)
QUOTA, 2, max entries one queue may hold when LL_QUOTA_EN is defined (1..DEPTH)
PTR_WIDTH, $clog2(DEPTH), derived
SEL_WIDTH, $clog2(NUM_FIFOS), derived

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
push_req  in  NUM_FIFOS  per-queue push request, bit i targets queue i
push_data  in  NUM_FIFOS*WIDTH  requester data, slice i = [i*WIDTH +: WIDTH]
pop_req  in  NUM_FIFOS  per-queue consumer ready to pop
push_gnt  out  NUM_FIFOS  one-hot/zero push grant, combinational, same cycle as request
pop_gnt  out  NUM_FIFOS  one-hot/zero pop grant, combinational
fifo_push  out  1  registered push to shared FIFO
fifo_push_sel  out  SEL_WIDTH  registered queue index for push
fifo_data_in  out  WIDTH  registered push data
fifo_pop  out  1  registered pop to shared FIFO
fifo_pop_sel  out  SEL_WIDTH  registered queue index for pop
q_count  out  NUM_FIFOS*(PTR_WIDTH+1)  per-queue occupancy, slice i for queue i
total_count  out  PTR_WIDTH+1  sum of q_count
full  out  1  total_count == DEPTH

Behaviour:
- Reset (rst==0 at posedge): all registered outputs 0; all counts 0; rr_push and rr_pop 0. Grants are 0 while rst==0.
- Push eligibility: elig_push[i] = push_req[i] & (total_count < DEPTH). Uses registered counts only; a same-cycle pop grant does not create push space.
- Pop eligibility: elig_pop[i] = pop_req[i] & (q_count[i] != 0). An entry pushed this cycle is not poppable this cycle.
- Round robin, independently for push and pop:
  - Scan indices rr, rr+1, ... mod NUM_FIFOS; the first eligible index wins.
  - On a grant, rr <= winner+1 mod NUM_FIFOS (correct wrap when NUM_FIFOS is not a power of two).
  - No grant: rr is unchanged.
- At most one push grant and one pop grant per cycle. Push and pop to the same queue in one cycle are legal when q_count[i] != 0.
- Next-cycle registers:
  - fifo_push <= |push_gnt; fifo_push_sel <= winner; fifo_data_in <= push_data slice of winner.
  - fifo_pop <= |pop_gnt; fifo_pop_sel <= winner.
  - When there is no grant: fifo_push/fifo_pop = 0; sel and data hold their previous values.
  - Latency is one cycle from grant to shared FIFO strobe.
- Counts:
  - q_count[i] += push grant to i; q_count[i] -= pop grant to i. Simultaneous push and pop to i leaves q_count[i] unchanged.
  - total_count is updated the same way (+1, -1, or net 0).
  - Counts update at the grant edge, concurrently with the strobe registers.
- Invariants:
  - total_count <= DEPTH.
  - q_count[i] never underflows.
  - The sum of q_count equals total_count.
- Reset mid-operation: all state clears on the next edge and in-flight registered strobes drop to 0. The shared FIFO is reset by the same rst.

Optional Feature:
- Macro: LL_QUOTA_EN.
- Defined: elig_push[i] additionally requires q_count[i] < QUOTA, so no queue can starve others of free entries.
- Undefined: only the total DEPTH limit applies, and QUOTA is ignored.

Test Plan:
1. Reset, then push_req=2'b01 for 5 cycles, DEPTH=4, no quota -> 4 grants; fifo_push is high on cycles 2-5; full=1; the 5th request gets no grant; q_count[0]=4.
2. push_req=2'b11 continuously from empty -> grants alternate 01,10,01,10; then full=1 and grants stop; q_count={2,2}.
3. q_count[1]=0, pop_req=2'b10 -> pop_gnt=0 and fifo_pop stays 0; push to queue 1, then next cycle -> pop_gnt=2'b10; fifo_pop=1 with fifo_pop_sel=1 one cycle later.
4. full=1, same cycle push_req=01 and pop_req=01 -> pop granted, push denied; next cycle push granted; total_count goes 4->3->4.
5. LL_QUOTA_EN, QUOTA=2, push_req=2'b01 only -> 2 grants then stall with total_count=2, full=0; asserting push_req[1] -> grants to queue 1.
6. Assert rst=0 mid-stream with fifo_push pending -> next edge fifo_push=0, all counts 0, rr pointers 0; first grant after release goes to the lowest eligible index.

Source files
------------

// File: rtl/ll_fifo_arbiter.sv
// Round-robin push/pop scheduler in front of the shared linked-list multi-queue FIFO.
// Optional per-queue occupancy cap: define LL_QUOTA_EN.
module ll_fifo_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int QUOTA     = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_FIFOS-1:0]               push_req,
    input  logic [NUM_FIFOS*WIDTH-1:0]         push_data,
    input  logic [NUM_FIFOS-1:0]               pop_req,
    output logic [NUM_FIFOS-1:0]               push_gnt,
    output logic [NUM_FIFOS-1:0]               pop_gnt,
    output logic                               fifo_push,
    output logic [SEL_WIDTH-1:0]               fifo_push_sel,
    output logic [WIDTH-1:0]                   fifo_data_in,
    output logic                               fifo_pop,
    output logic [SEL_WIDTH-1:0]               fifo_pop_sel,
    output logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0] q_count,
    output logic [PTR_WIDTH:0]                 total_count,
    output logic                               full
);

    localparam int CW = PTR_WIDTH + 1;
`ifdef LL_QUOTA_EN
    localparam bit QUOTA_ON = 1'b1;
`else
    localparam bit QUOTA_ON = 1'b0;
`endif
    // Without the quota the per-queue cap degenerates to DEPTH, already implied by the total limit.
    localparam int QLIM = QUOTA_ON ? QUOTA : DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] QLIM_C  = CW'(QLIM);

    logic [NUM_FIFOS-1:0][CW-1:0] cnt;
    logic [CW-1:0]                tot;
    logic [SEL_WIDTH-1:0]         rr_push, rr_pop;
    logic [SEL_WIDTH-1:0]         win_push, win_pop;
    logic                         found_push, found_pop;
    logic [NUM_FIFOS-1:0]         elig_push, elig_pop;

    // Returns {found, index} of the first set bit scanning upward from rr with wrap.
    function automatic logic [SEL_WIDTH:0] rr_pick(input logic [NUM_FIFOS-1:0] el,
                                                   input logic [SEL_WIDTH-1:0] rr);
        logic [SEL_WIDTH:0]   res;
        logic [SEL_WIDTH-1:0] sel;
        int                   idx;
        res = '0;
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
            sel = idx[SEL_WIDTH-1:0];
            if (el[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] rr_next(input logic [SEL_WIDTH-1:0] w);
        return (int'(w) == NUM_FIFOS - 1) ? '0 : w + 1'b1;
    endfunction

    // Eligibility uses registered counts only: same-cycle grants never create space or data.
    always_comb begin
        elig_push = '0;
        elig_pop  = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            elig_push[i] = rst & push_req[i] & (tot < DEPTH_C) & (cnt[i] < QLIM_C);
            elig_pop[i]  = rst & pop_req[i] & (cnt[i] != '0);
        end
    end

    assign {found_push, win_push} = rr_pick(elig_push, rr_push);
    assign {found_pop,  win_pop}  = rr_pick(elig_pop,  rr_pop);

    always_comb begin
        push_gnt = '0;
        pop_gnt  = '0;
        if (found_push) push_gnt[win_push] = 1'b1;
        if (found_pop)  pop_gnt[win_pop]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_push     <= 1'b0;
            fifo_push_sel <= '0;
            fifo_data_in  <= '0;
            fifo_pop      <= 1'b0;
            fifo_pop_sel  <= '0;
            rr_push       <= '0;
            rr_pop        <= '0;
            cnt           <= '0;
            tot           <= '0;
        end else begin
            fifo_push <= found_push;
            fifo_pop  <= found_pop;
            if (found_push) begin
                fifo_push_sel <= win_push;
                fifo_data_in  <= push_data[win_push*WIDTH +: WIDTH];
                rr_push       <= rr_next(win_push);
            end
            if (found_pop) begin
                fifo_pop_sel <= win_pop;
                rr_pop       <= rr_next(win_pop);
            end
            for (int i = 0; i < NUM_FIFOS; i++) begin
                case ({push_gnt[i], pop_gnt[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: ;
                endcase
            end
            case ({found_push, found_pop})
                2'b10:   tot <= tot + 1'b1;
                2'b01:   tot <= tot - 1'b1;
                default: ;
            endcase
        end
    end

    assign q_count     = cnt;
    assign total_count = tot;
    assign full        = (tot == DEPTH_C);

endmodule

// File: tb/tb_ll_fifo_arbiter.sv
// Directed bench for ll_fifo_arbiter: occupancy/round-robin model checked every cycle plus literal checks.
module tb_ll_fifo_arbiter;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int N  = 2;
    localparam int Q  = 2;
    localparam int CW = 3;
    localparam int SW = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      push_req = '0;
    logic [N*W-1:0]    push_data = '0;
    logic [N-1:0]      pop_req = '0;
    logic [N-1:0]      push_gnt, pop_gnt;
    logic              fifo_push, fifo_pop, full;
    logic [SW-1:0]     fifo_push_sel, fifo_pop_sel;
    logic [W-1:0]      fifo_data_in;
    logic [N*CW-1:0]   q_count;
    logic [CW-1:0]     total_count;

    ll_fifo_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(N), .QUOTA(Q)) dut (
        .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .push_gnt(push_gnt), .pop_gnt(pop_gnt), .fifo_push(fifo_push),
        .fifo_push_sel(fifo_push_sel), .fifo_data_in(fifo_data_in), .fifo_pop(fifo_pop),
        .fifo_pop_sel(fifo_pop_sel), .q_count(q_count), .total_count(total_count), .full(full)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: occupancy per queue, round-robin pointers, expected registered strobes.
    int qc[N];
    int tot, rrp, rro;
    int e_fp, e_fps, e_fd, e_fo, e_fos;

    function automatic int pick(input logic [N-1:0] el, input int rr);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = el >> ((rr + k) % N);
            if (t[0]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] push_elig();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) begin
            e[i] = rst && push_req[i] && (tot < D);
`ifdef LL_QUOTA_EN
            e[i] = e[i] && (qc[i] < Q);
`endif
        end
        return e;
    endfunction

    function automatic logic [N-1:0] pop_elig();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) e[i] = rst && pop_req[i] && (qc[i] > 0);
        return e;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v = N'(1) << w;
        return v;
    endfunction

    always @(posedge clk) begin
        int wp, wo;
        if (!rst) begin
            for (int i = 0; i < N; i++) qc[i] = 0;
            tot = 0; rrp = 0; rro = 0;
            e_fp = 0; e_fps = 0; e_fd = 0; e_fo = 0; e_fos = 0;
        end else begin
            wp = pick(push_elig(), rrp);
            wo = pick(pop_elig(), rro);
            e_fp = (wp >= 0) ? 1 : 0;
            e_fo = (wo >= 0) ? 1 : 0;
            if (wp >= 0) begin
                e_fps = wp; e_fd = int'(push_data[wp*W +: W]);
                qc[wp]++; tot++; rrp = (wp + 1) % N;
            end
            if (wo >= 0) begin
                e_fos = wo; qc[wo]--; tot--; rro = (wo + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("push_gnt", 64'(push_gnt), 64'(onehot(pick(push_elig(), rrp))));
            chk("pop_gnt", 64'(pop_gnt), 64'(onehot(pick(pop_elig(), rro))));
            chk("fifo_push", 64'(fifo_push), 64'(e_fp));
            chk("fifo_push_sel", 64'(fifo_push_sel), 64'(e_fps));
            chk("fifo_data_in", 64'(fifo_data_in), 64'(e_fd));
            chk("fifo_pop", 64'(fifo_pop), 64'(e_fo));
            chk("fifo_pop_sel", 64'(fifo_pop_sel), 64'(e_fos));
            for (int i = 0; i < N; i++)
                chk($sformatf("q_count[%0d]", i), 64'(q_count[i*CW +: CW]), 64'(qc[i]));
            chk("total_count", 64'(total_count), 64'(tot));
            chk("full", 64'(full), 64'(tot == D));
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input logic [N-1:0] pr, input logic [N-1:0] pp);
        push_req = pr;
        pop_req  = pp;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b0; push_req = '0; pop_req = '0;
        adv();
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        at_neg(2'b11, 2'b11);
        chk("rst_push_gnt", 64'(push_gnt), 64'd0);
        chk("rst_fifo_push", 64'(fifo_push), 64'd0);
        chk("rst_total", 64'(total_count), 64'd0);
        adv();
        rst = 1'b1;

        // Single requester on queue 0.
        for (int i = 0; i < 5; i++) begin
            push_data = {8'hB0 + 8'(i), 8'hA0 + 8'(i)};
`ifdef LL_QUOTA_EN
            at_neg(2'b01, 2'b00);
            if (i < 2) chk("t5_gnt", 64'(push_gnt), 64'b01);
            if (i >= 2) chk("t5_stall", 64'(push_gnt), 64'b00);
            if (i == 4) chk("t5_total", 64'(total_count), 64'd2);
            if (i == 4) chk("t5_full", 64'(full), 64'd0);
`else
            at_neg(2'b01, 2'b00);
            if (i < 4) chk("t1_gnt", 64'(push_gnt), 64'b01);
            if (i == 4) chk("t1_gnt5", 64'(push_gnt), 64'b00);
            if (i == 4) chk("t1_full", 64'(full), 64'd1);
            if (i == 4) chk("t1_q0", 64'(q_count[CW-1:0]), 64'd4);
`endif
            if (i >= 1) chk("t1_fifo_push", 64'(fifo_push), 64'd1);
            if (i == 1) chk("t1_data", 64'(fifo_data_in), 64'hA0);
            adv();
        end
`ifdef LL_QUOTA_EN
        at_neg(2'b11, 2'b00);
        chk("t5_q1_gnt", 64'(push_gnt), 64'b10);
        adv();
`endif
        repeat (5) begin at_neg(2'b00, 2'b11); adv(); end

        // Two requesters alternate until full.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            push_data = {8'hC0 + 8'(i), 8'hD0 + 8'(i)};
            at_neg(2'b11, 2'b00);
            if (i < 4) chk("t2_gnt", 64'(push_gnt), 64'(exp_seq[i]));
            if (i == 4) chk("t2_stop", 64'(push_gnt), 64'b00);
            adv();
        end
        at_neg(2'b00, 2'b00);
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_qcount", 64'(q_count), 64'b010_010);
        adv();

        // Full: pop wins, push waits one cycle.
        at_neg(2'b01, 2'b01);
        chk("t4_pop", 64'(pop_gnt), 64'b01);
        chk("t4_push", 64'(push_gnt), 64'b00);
        chk("t4_tot4", 64'(total_count), 64'd4);
        adv();
        at_neg(2'b01, 2'b00);
        chk("t4_push2", 64'(push_gnt), 64'b01);
        chk("t4_tot3", 64'(total_count), 64'd3);
        adv();
        at_neg(2'b00, 2'b00);
        chk("t4_tot4b", 64'(total_count), 64'd4);
        adv();

        // Pop of an empty queue is refused; data pushed this cycle is not poppable yet.
        reset_dut();
        at_neg(2'b00, 2'b10);
        chk("t3_nopop", 64'(pop_gnt), 64'b00);
        adv();
        push_data = 16'h5A00;
        at_neg(2'b10, 2'b10);
        chk("t3_nopop2", 64'(pop_gnt), 64'b00);
        chk("t3_push", 64'(push_gnt), 64'b10);
        chk("t3_fifo_pop0", 64'(fifo_pop), 64'd0);
        adv();
        at_neg(2'b00, 2'b10);
        chk("t3_pop", 64'(pop_gnt), 64'b10);
        adv();
        at_neg(2'b00, 2'b00);
        chk("t3_fifo_pop", 64'(fifo_pop), 64'd1);
        chk("t3_pop_sel", 64'(fifo_pop_sel), 64'd1);
        adv();

        // Reset with a strobe in flight and rr_push advanced.
        push_data = 16'h3311;
        at_neg(2'b01, 2'b00);
        adv();
        rst = 1'b0;
        at_neg(2'b11, 2'b00);
        chk("t6_gnt_rst", 64'(push_gnt), 64'b00);
        chk("t6_pending", 64'(fifo_push), 64'd1);
        adv();
        rst = 1'b1;
        at_neg(2'b11, 2'b00);
        chk("t6_fifo_push", 64'(fifo_push), 64'd0);
        chk("t6_total", 64'(total_count), 64'd0);
        chk("t6_q", 64'(q_count), 64'd0);
        chk("t6_first", 64'(push_gnt), 64'b01);
        adv();

        // Mixed traffic, occasional reset; model checks every cycle.
        for (int c = 0; c < 400; c++) begin
            push_data = 16'($urandom);
            rst = ($urandom_range(0, 60) != 0);
            at_neg(N'($urandom), N'($urandom));
            adv();
        end
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
